// File: rtl/rw_port_arbiter_pkg.sv
// Shared types and defaults for the rw port arbiter: FSM state encoding,
// owner identifiers, default transaction IDs and the bus-error helper.
package rw_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  localparam int DEF_IF_ID  = 0;
  localparam int DEF_MEM_ID = 1;

  // Any non-OKAY AXI response (SLVERR/DECERR/EXOKAY) is reported as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return |resp;
  endfunction

endpackage

// File: rtl/rw_port_arbiter.sv
// Round-robin arbiter sharing the single axi_master_if rw port between
// instruction fetch (read-only) and load/store; the winner's command is registered.
module rw_port_arbiter
  import rw_port_arbiter_pkg::*;
#(
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 32,
  parameter int RW_ID_WIDTH   = 4,
  parameter int IF_ID         = DEF_IF_ID,
  parameter int MEM_ID        = DEF_MEM_ID
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         if_cen_i,
  input  logic [RW_ADDR_WIDTH-1:0]     if_addr_i,
  input  logic [2:0]                   if_size_i,
  output logic                         if_ready_o,
  output logic [RW_DATA_WIDTH-1:0]     if_rdata_o,
  output logic                         if_err_o,
  input  logic                         mem_cen_i,
  input  logic                         mem_wen_i,
  input  logic [RW_ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [2:0]                   mem_size_i,
  input  logic [RW_DATA_WIDTH-1:0]     mem_wdata_i,
  input  logic [RW_DATA_WIDTH/8-1:0]   mem_wmask_i,
  output logic                         mem_ready_o,
  output logic [RW_DATA_WIDTH-1:0]     mem_rdata_o,
  output logic                         mem_err_o,
  output logic                         rw_cen_o,
  output logic                         rw_wen_o,
  output logic [RW_ID_WIDTH-1:0]       rw_id_o,
  output logic [RW_ADDR_WIDTH-1:0]     rw_addr_o,
  output logic [2:0]                   rw_size_o,
  output logic [RW_DATA_WIDTH-1:0]     rw_wdata_o,
  output logic [RW_DATA_WIDTH/8-1:0]   rw_wmask_o,
  input  logic                         rw_ready_i,
  input  logic [RW_DATA_WIDTH-1:0]     rw_rdata_i,
  input  logic [1:0]                   rw_resp_i
);

  localparam int MW = RW_DATA_WIDTH / 8;

  arb_state_e               state_r, state_nxt_s;
  owner_e                   last_grant_r, last_grant_nxt_s;
  logic                     load_s, load_mem_s;
  logic                     cen_r;
  logic                     wen_r;
  logic [RW_ID_WIDTH-1:0]   id_r;
  logic [RW_ADDR_WIDTH-1:0] addr_r;
  logic [2:0]               size_r;
  logic [RW_DATA_WIDTH-1:0] wdata_r;
  logic [MW-1:0]            wmask_r;
  logic                     if_done_s, mem_done_s;

  // Next-state, grant selection and round-robin history update.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    load_s           = 1'b0;
    load_mem_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (if_cen_i && mem_cen_i) begin
          load_s     = 1'b1;
          load_mem_s = (last_grant_r == OWNER_IF);
        end else if (mem_cen_i) begin
          load_s     = 1'b1;
          load_mem_s = 1'b1;
        end else if (if_cen_i) begin
          load_s     = 1'b1;
          load_mem_s = 1'b0;
        end else begin
          load_s     = 1'b0;
          load_mem_s = 1'b0;
        end
        if (!load_s) begin
          state_nxt_s = ST_IDLE;
        end else if (load_mem_s) begin
          state_nxt_s = ST_BUSY_MEM;
        end else begin
          state_nxt_s = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF: begin
        if (rw_ready_i) begin
          state_nxt_s      = ST_IDLE;
          last_grant_nxt_s = OWNER_IF;
        end else begin
          state_nxt_s = ST_BUSY_IF;
        end
      end
      ST_BUSY_MEM: begin
        if (rw_ready_i) begin
          state_nxt_s      = ST_IDLE;
          last_grant_nxt_s = OWNER_MEM;
        end else begin
          state_nxt_s = ST_BUSY_MEM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, grant history and rw_cen register; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= OWNER_IF;
      cen_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      cen_r        <= (state_nxt_s != ST_IDLE);
    end
  end

  // Command capture on grant; IF is read-only so wen/wmask/wdata are forced low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_r   <= 1'b0;
      id_r    <= '0;
      addr_r  <= '0;
      size_r  <= 3'd0;
      wdata_r <= '0;
      wmask_r <= '0;
    end else if (load_s && load_mem_s) begin
      wen_r   <= mem_wen_i;
      id_r    <= RW_ID_WIDTH'(MEM_ID);
      addr_r  <= mem_addr_i;
      size_r  <= mem_size_i;
      wdata_r <= mem_wdata_i;
      wmask_r <= mem_wmask_i;
    end else if (load_s) begin
      wen_r   <= 1'b0;
      id_r    <= RW_ID_WIDTH'(IF_ID);
      addr_r  <= if_addr_i;
      size_r  <= if_size_i;
      wdata_r <= '0;
      wmask_r <= '0;
    end else begin
      wen_r   <= wen_r;
      id_r    <= id_r;
      addr_r  <= addr_r;
      size_r  <= size_r;
      wdata_r <= wdata_r;
      wmask_r <= wmask_r;
    end
  end

  assign rw_cen_o   = cen_r;
  assign rw_wen_o   = wen_r;
  assign rw_id_o    = id_r;
  assign rw_addr_o  = addr_r;
  assign rw_size_o  = size_r;
  assign rw_wdata_o = wdata_r;
  assign rw_wmask_o = wmask_r;

  // Completion is routed combinationally to the owner only; ready in IDLE is dropped.
  assign if_done_s  = (state_r == ST_BUSY_IF)  && rw_ready_i;
  assign mem_done_s = (state_r == ST_BUSY_MEM) && rw_ready_i;

  assign if_ready_o  = if_done_s;
  assign if_rdata_o  = if_done_s ? rw_rdata_i : '0;
  assign if_err_o    = if_done_s && resp_is_err(rw_resp_i);
  assign mem_ready_o = mem_done_s;
  assign mem_rdata_o = mem_done_s ? rw_rdata_i : '0;
  assign mem_err_o   = mem_done_s && resp_is_err(rw_resp_i);

endmodule

// File: tb/tb_rw_port_arbiter.sv
// Self-checking bench for rw_port_arbiter: directed scenarios plus randomized
// traffic checked against a round-robin ownership model.
module tb_rw_port_arbiter;

  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int IDW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            if_cen, if_ready, if_err;
  logic [AW-1:0]   if_addr;
  logic [2:0]      if_size;
  logic [DW-1:0]   if_rdata;
  logic            mem_cen, mem_wen, mem_ready, mem_err;
  logic [AW-1:0]   mem_addr;
  logic [2:0]      mem_size;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_wmask;
  logic            rw_cen, rw_wen, rw_ready;
  logic [IDW-1:0]  rw_id;
  logic [AW-1:0]   rw_addr;
  logic [2:0]      rw_size;
  logic [DW-1:0]   rw_wdata, rw_rdata;
  logic [DW/8-1:0] rw_wmask;
  logic [1:0]      rw_resp;

  int n_checks = 0;
  int n_pass   = 0;
  bit last_mem = 1'b0;  // model: most recent owner was MEM

  rw_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_cen_i(if_cen), .if_addr_i(if_addr), .if_size_i(if_size),
    .if_ready_o(if_ready), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .mem_cen_i(mem_cen), .mem_wen_i(mem_wen), .mem_addr_i(mem_addr),
    .mem_size_i(mem_size), .mem_wdata_i(mem_wdata), .mem_wmask_i(mem_wmask),
    .mem_ready_o(mem_ready), .mem_rdata_o(mem_rdata), .mem_err_o(mem_err),
    .rw_cen_o(rw_cen), .rw_wen_o(rw_wen), .rw_id_o(rw_id), .rw_addr_o(rw_addr),
    .rw_size_o(rw_size), .rw_wdata_o(rw_wdata), .rw_wmask_o(rw_wmask),
    .rw_ready_i(rw_ready), .rw_rdata_i(rw_rdata), .rw_resp_i(rw_resp)
  );

  // One full transaction: expected owner from round-robin rule, grant wait,
  // command check, optional owner-input perturbation, completion routing.
  task automatic do_txn(input bit perturb, input int delay, input logic [DW-1:0] rd,
                        input logic [1:0] resp, output int lat);
    bit              own_mem, seen;
    logic [IDW-1:0]  e_id;
    logic            e_wen;
    logic [AW-1:0]   e_addr;
    logic [2:0]      e_size;
    logic [DW-1:0]   e_wdata;
    logic [DW/8-1:0] e_wmask;
    if (if_cen && mem_cen) own_mem = !last_mem;
    else own_mem = mem_cen;
    if (own_mem) begin
      e_id = 4'd1; e_wen = mem_wen; e_addr = mem_addr; e_size = mem_size;
      e_wdata = mem_wdata; e_wmask = mem_wmask;
    end else begin
      e_id = 4'd0; e_wen = 1'b0; e_addr = if_addr; e_size = if_size;
      e_wdata = rw_wdata; e_wmask = 8'h00;
    end
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (rw_cen === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL grant_timeout: rw_cen_o=%b after %0d cycles, required 1", rw_cen, lat);
      return;
    end else n_pass++;
    if (!own_mem) e_wdata = rw_wdata;  // IF write data is don't-care
    n_checks++;
    if ({rw_id, rw_wen, rw_addr, rw_size, rw_wmask, rw_wdata} !== {e_id, e_wen, e_addr, e_size, e_wmask, e_wdata})
      $display("FAIL cmd: got id=%h wen=%b addr=%h size=%h wmask=%h wdata=%h, required id=%h wen=%b addr=%h size=%h wmask=%h wdata=%h",
               rw_id, rw_wen, rw_addr, rw_size, rw_wmask, rw_wdata, e_id, e_wen, e_addr, e_size, e_wmask, e_wdata);
    else n_pass++;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      if (perturb) begin
        if (own_mem) begin
          mem_addr = ~mem_addr; mem_wdata = ~mem_wdata; mem_wen = ~mem_wen;
        end else begin
          if_addr = ~if_addr; if_size = ~if_size;
        end
      end
      @(negedge clk);
      n_checks++;
      if ({rw_cen, rw_addr, rw_wen, rw_size, rw_wdata, if_ready, mem_ready} !==
          {1'b1, e_addr, e_wen, e_size, e_wdata, 1'b0, 1'b0})
        $display("FAIL busy_hold: got cen=%b addr=%h wen=%b size=%h ready=%b%b, required cen=1 addr=%h wen=%b size=%h ready=00",
                 rw_cen, rw_addr, rw_wen, rw_size, if_ready, mem_ready, e_addr, e_wen, e_size);
      else n_pass++;
    end
    @(posedge clk); #1;
    rw_ready = 1'b1; rw_rdata = rd; rw_resp = resp;
    @(negedge clk);
    n_checks++;
    if (own_mem) begin
      if ({mem_ready, mem_rdata, mem_err, if_ready, if_rdata, if_err} !== {1'b1, rd, resp != 2'b00, 1'b0, 64'd0, 1'b0})
        $display("FAIL mem_done: got ready=%b rdata=%h err=%b if=%b/%h/%b, required 1/%h/%b if=0/0/0",
                 mem_ready, mem_rdata, mem_err, if_ready, if_rdata, if_err, rd, resp != 2'b00);
      else n_pass++;
    end else begin
      if ({if_ready, if_rdata, if_err, mem_ready, mem_rdata, mem_err} !== {1'b1, rd, resp != 2'b00, 1'b0, 64'd0, 1'b0})
        $display("FAIL if_done: got ready=%b rdata=%h err=%b mem=%b/%h/%b, required 1/%h/%b mem=0/0/0",
                 if_ready, if_rdata, if_err, mem_ready, mem_rdata, mem_err, rd, resp != 2'b00);
      else n_pass++;
    end
    @(posedge clk); #1;
    rw_ready = 1'b0; rw_rdata = {$urandom, $urandom}; rw_resp = 2'b00;
    if (own_mem) mem_cen = 1'b0;
    else if_cen = 1'b0;
    last_mem = own_mem;
    @(negedge clk);
    n_checks++;
    if ({rw_cen, if_ready, mem_ready} !== 3'b000)
      $display("FAIL gap: got cen=%b ready=%b%b, required 000", rw_cen, if_ready, mem_ready);
    else n_pass++;
  endtask

  task automatic new_if_req();
    if_cen = 1'b1; if_addr = $urandom; if_size = 3'($urandom_range(0, 3));
  endtask

  task automatic new_mem_req();
    mem_cen = 1'b1; mem_wen = 1'($urandom); mem_addr = $urandom;
    mem_size = 3'($urandom_range(0, 3)); mem_wdata = {$urandom, $urandom};
    mem_wmask = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rw_ready = 1'b1; rw_resp = 2'b11; rw_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rw_cen, rw_wen, rw_id, rw_addr, rw_size, rw_wdata, rw_wmask, if_ready, if_rdata, if_err,
         mem_ready, mem_rdata, mem_err} !== '0)
      $display("FAIL reset_in: got cen=%b id=%h addr=%h ready=%b%b err=%b%b, required all 0",
               rw_cen, rw_id, rw_addr, if_ready, mem_ready, if_err, mem_err);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rw_cen, rw_id, rw_addr, if_ready, if_err, mem_ready, mem_err, if_rdata, mem_rdata} !== '0)
      $display("FAIL reset_out: got cen=%b id=%h addr=%h ready=%b%b, required all 0",
               rw_cen, rw_id, rw_addr, if_ready, mem_ready);
    else n_pass++;
    @(posedge clk); #1;
    rw_ready = 1'b0; rw_resp = 2'b00;
    last_mem = 1'b0;
  endtask

  task automatic test_if_read();
    int lat;
    @(posedge clk); #1;
    if_cen = 1'b1; if_addr = 32'h8000_0000; if_size = 3'd2;
    do_txn(1'b0, 5, 64'h1234, 2'b00, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL if_latency: got %0d, required 2", lat);
    else n_pass++;
  endtask

  task automatic test_mem_write();
    int lat;
    @(posedge clk); #1;
    mem_cen = 1'b1; mem_wen = 1'b1; mem_addr = 32'h8000_1008; mem_size = 3'd3;
    mem_wdata = 64'hDEAD_BEEF; mem_wmask = 8'h0F;
    do_txn(1'b0, 2, 64'h0, 2'b00, lat);
  endtask

  task automatic test_tie_rr();
    int lat;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      new_if_req();
      new_mem_req();
      do_txn(1'b0, 1, {$urandom, $urandom}, 2'b00, lat);
      do_txn(1'b0, 0, {$urandom, $urandom}, 2'b00, lat);
    end
  endtask

  task automatic test_mem_err();
    int lat;
    @(posedge clk); #1;
    new_mem_req();
    mem_wen = 1'b0;
    do_txn(1'b0, 1, 64'hCAFE, 2'b10, lat);
  endtask

  task automatic test_idle_ready();
    @(posedge clk); #1;
    rw_ready = 1'b1; rw_rdata = 64'h55; rw_resp = 2'b10;
    @(negedge clk);
    n_checks++;
    if ({rw_cen, if_ready, mem_ready, if_err, mem_err, if_rdata, mem_rdata} !== '0)
      $display("FAIL idle_ready: got cen=%b ready=%b%b err=%b%b, required all 0",
               rw_cen, if_ready, mem_ready, if_err, mem_err);
    else n_pass++;
    @(posedge clk); #1;
    rw_ready = 1'b0; rw_resp = 2'b00;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    @(posedge clk); #1;
    new_mem_req();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rw_cen === 1'b1) seen = 1'b1;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({seen, rw_cen, rw_addr, mem_ready} !== {1'b1, 1'b0, 32'd0, 1'b0})
      $display("FAIL reset_mid: got granted=%b cen=%b addr=%h ready=%b, required 1/0/0/0",
               seen, rw_cen, rw_addr, mem_ready);
    else n_pass++;
    mem_cen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_mem = 1'b0;
    @(posedge clk); #1;
    new_if_req();
    new_mem_req();
    do_txn(1'b0, 0, 64'h77, 2'b00, lat);
    do_txn(1'b0, 0, 64'h88, 2'b00, lat);
  endtask

  task automatic test_addr_change();
    int lat;
    @(posedge clk); #1;
    new_mem_req();
    do_txn(1'b1, 4, 64'h99, 2'b00, lat);
    @(posedge clk); #1;
    new_if_req();
    do_txn(1'b1, 3, 64'hAA, 2'b00, lat);
  endtask

  task automatic test_random();
    int lat;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (!if_cen && $urandom_range(0, 1) == 1) new_if_req();
      if (!mem_cen && $urandom_range(0, 1) == 1) new_mem_req();
      if (!if_cen && !mem_cen) new_if_req();
      do_txn(1'($urandom), int'($urandom_range(0, 4)), {$urandom, $urandom},
             2'($urandom_range(0, 3)), lat);
    end
  endtask

  initial begin
    if_cen = 1'b0; if_addr = '0; if_size = 3'd0;
    mem_cen = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_size = 3'd0;
    mem_wdata = '0; mem_wmask = '0;
    rw_ready = 1'b0; rw_rdata = '0; rw_resp = 2'b00;
    rst_n = 1'b0;
    test_reset();
    test_if_read();
    test_mem_write();
    test_tie_rr();
    test_mem_err();
    test_idle_ready();
    test_reset_mid();
    test_addr_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
